// File: rtl/uart_rx_buffered_if.sv
// Receive-side bus of the buffered UART receiver: serial input, FIFO pop
// handshake, head byte, FIFO status flags and the two error pulses.
interface uart_rx_buffered_if;
    logic       rxd;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rxd, rd_en,
        input  dout, empty, full, frame_err, overrun
    );

    modport slave (
        input  rxd, rd_en,
        output dout, empty, full, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver sampling at bit centres, feeding a first-word-fall-through
// byte FIFO with registered status outputs, frame error and overrun pulses.
module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    uart_rx_buffered_if.slave    bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ZERO_C  = {(AW + 1){1'b0}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic          sync1_r;
    logic          line_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;
    logic          wr_r;
    logic          ferr_r;

    logic [7:0]    mem_r [0:FIFO_DEPTH-1];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;
    logic          empty_r;
    logic          full_r;
    logic [7:0]    dout_r;
    logic          ovr_r;

    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW:0]   count_nxt_s;
    logic [7:0]    head_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_r <= 1'b1;
            line_r  <= 1'b1;
        end else begin
            sync1_r <= bus.rxd;
            line_r  <= sync1_r;
        end
    end

    // Receive FSM: half-bit start qualification, then one sample per bit centre.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            wr_r    <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            wr_r   <= 1'b0;
            ferr_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!line_r) begin
                        state_r <= START;
                        cnt_r   <= '0;
                    end
                end
                START: begin
                    if (cnt_r == HALF_C) begin
                        cnt_r   <= '0;
                        idx_r   <= 3'd0;
                        state_r <= line_r ? IDLE : DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == LAST_C) begin
                        cnt_r          <= '0;
                        shift_r[idx_r] <= line_r;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == LAST_C) begin
                        cnt_r <= '0;
                        if (line_r) begin
                            wr_r    <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            ferr_r  <= 1'b1;
                            state_r <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (line_r) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // FIFO next-state; a write into a full FIFO is only accepted alongside a pop.
    always_comb begin
        pop_s  = bus.rd_en & ~empty_r;
        push_s = wr_r & (~full_r | pop_s);
        drop_s = wr_r & full_r & ~pop_s;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (AW + 1)'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - (AW + 1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
        // The byte being written bypasses storage when it becomes the new head.
        if (count_nxt_s == ZERO_C) begin
            head_s = 8'h00;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_s = shift_r;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Byte storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and registered head/status/overrun outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= ZERO_C;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            dout_r   <= 8'h00;
            ovr_r    <= 1'b0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == ZERO_C);
            full_r   <= (count_nxt_s == DEPTH_C);
            dout_r   <= head_s;
            ovr_r    <= drop_s;
        end
    end

    assign bus.dout      = dout_r;
    assign bus.empty     = empty_r;
    assign bus.full      = full_r;
    assign bus.frame_err = ferr_r;
    assign bus.overrun   = ovr_r;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed scenarios plus random
// frames checked against a queue model of the receive FIFO.
module tb_uart_rx_buffered;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic clr;
    uart_rx_buffered_if bus();

    uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;
    int long_cnt = 0;
    logic prev_f = 1'b0;
    logic prev_o = 1'b0;
    logic [7:0] model_q [$];

    // Pulse monitor: counts error pulses, coincidences and pulses longer than one cycle.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.overrun === 1'b1) ovr_cnt++;
        if (bus.frame_err === 1'b1 && bus.overrun === 1'b1) both_cnt++;
        if (bus.frame_err === 1'b1 && prev_f === 1'b1) long_cnt++;
        if (bus.overrun === 1'b1 && prev_o === 1'b1) long_cnt++;
        prev_f = bus.frame_err;
        prev_o = bus.overrun;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Drives one frame: start, 8 data bits LSB first, stop (low for two bit times
    // when stop_ok=0). pop_at / clr_at give the frame-relative cycle for a one-cycle
    // rd_en or clr pulse (-1 = none). Ends with six idle cycles.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int pop_at, input int clr_at);
        logic [9:0] frame;
        frame = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
        for (int t = 0; t < 10 * CPB; t++) begin
            @(negedge clk);
            bus.rxd = frame[t / CPB];
            if (pop_at >= 0) bus.rd_en = (t == pop_at);
            if (clr_at >= 0) clr = (t == clr_at);
        end
        if (!stop_ok) begin
            repeat (CPB) @(negedge clk);
        end
        @(negedge clk);
        bus.rxd   = 1'b1;
        bus.rd_en = 1'b0;
        clr       = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.rxd = 1'b1;
        bus.rd_en = 1'b0;
        #5;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
        n_checks++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", bus.frame_err, bus.overrun); end
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int f0, o0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h55, 1'b1, -1, -1);
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", bus.empty); end
        n_checks++; if (bus.dout !== 8'h55) begin n_fail++; $display("FAIL single_dout: got %h want 55", bus.dout); end
        n_checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL single_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
        pop_one();
        n_checks++; if (bus.empty !== 1'b1 || bus.dout !== 8'h00) begin n_fail++; $display("FAIL single_drain: got empty=%b dout=%h want 1 00", bus.empty, bus.dout); end
    endtask

    task automatic test_glitch();
        int f0, o0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        @(negedge clk); bus.rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b want 1", bus.empty); end
        n_checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL glitch_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
        send_frame(8'hC6, 1'b1, -1, -1);
        n_checks++; if (bus.dout !== 8'hC6) begin n_fail++; $display("FAIL glitch_recover: got %h want c6", bus.dout); end
        pop_one();
    endtask

    task automatic test_frame_err();
        int f0, o0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA3, 1'b0, -1, -1);
        n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ferr_empty: got %b want 1", bus.empty); end
        send_frame(8'h3C, 1'b1, -1, -1);
        n_checks++; if (bus.empty !== 1'b0 || bus.dout !== 8'h3C) begin n_fail++; $display("FAIL ferr_next: got empty=%b dout=%h want 0 3c", bus.empty, bus.dout); end
        n_checks++; if (ferr_cnt - f0 != 1 || ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL ferr_flags: got ferr=%0d ovr=%0d want 1 0", ferr_cnt - f0, ovr_cnt - o0); end
        pop_one();
    endtask

    task automatic test_overrun(input bit pop_during_write);
        int o0;
        logic [7:0] first;
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, -1);
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovr_full4: got %b want 1", bus.full); end
        send_frame(8'h05, 1'b1, pop_during_write ? 10 * CPB - 1 : -1, -1);
        n_checks++; if (ovr_cnt - o0 != (pop_during_write ? 0 : 1)) begin n_fail++; $display("FAIL ovr_pulses: got %0d want %0d", ovr_cnt - o0, pop_during_write ? 0 : 1); end
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovr_full5: got %b want 1", bus.full); end
        first = pop_during_write ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.dout !== first + 8'(i) || bus.empty !== 1'b0) begin n_fail++; $display("FAIL ovr_pop%0d: got %h want %h", i, bus.dout, first + 8'(i)); end
            pop_one();
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drained: got %b want 1", bus.empty); end
    endtask

    task automatic test_clr_midframe();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'hFF, 1'b1, -1, 5 * CPB + CPB / 2);
        send_frame(8'h81, 1'b1, -1, -1);
        n_checks++; if (bus.empty !== 1'b0 || bus.dout !== 8'h81) begin n_fail++; $display("FAIL clr_head: got empty=%b dout=%h want 0 81", bus.empty, bus.dout); end
        pop_one();
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL clr_count: got empty=%b want 1 after one pop", bus.empty); end
        n_checks++; if (ferr_cnt != f0) begin n_fail++; $display("FAIL clr_flags: got ferr=%0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_random();
        int f0, o0, exp_f, exp_o, npop;
        logic [7:0] b;
        bit ok;
        f0 = ferr_cnt; o0 = ovr_cnt; exp_f = 0; exp_o = 0;
        model_q.delete();
        for (int i = 0; i < 14; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, -1, -1);
            if (!ok) exp_f++;
            else if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_o++;
            npop = (i % 5 == 4) ? 0 : $urandom_range(0, 1);
            for (int j = 0; j < npop; j++) begin
                pop_one();
                if (model_q.size() > 0) void'(model_q.pop_front());
            end
            n_checks++; if (bus.empty !== (model_q.size() == 0) || bus.full !== (model_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_status%0d: got empty=%b full=%b want size %0d", i, bus.empty, bus.full, model_q.size()); end
            n_checks++; if (bus.dout !== ((model_q.size() > 0) ? model_q[0] : 8'h00)) begin n_fail++; $display("FAIL rnd_dout%0d: got %h want %h", i, bus.dout, (model_q.size() > 0) ? model_q[0] : 8'h00); end
        end
        n_checks++; if (ferr_cnt - f0 != exp_f || ovr_cnt - o0 != exp_o) begin n_fail++; $display("FAIL rnd_flags: got ferr=%0d ovr=%0d want %0d %0d", ferr_cnt - f0, ovr_cnt - o0, exp_f, exp_o); end
        while (model_q.size() > 0) begin
            n_checks++; if (bus.dout !== model_q[0]) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", bus.dout, model_q[0]); end
            pop_one();
            void'(model_q.pop_front());
        end
        pop_one();
        n_checks++; if (bus.empty !== 1'b1 || bus.dout !== 8'h00) begin n_fail++; $display("FAIL rnd_empty_pop: got empty=%b dout=%h want 1 00", bus.empty, bus.dout); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun(1'b0);
        test_clr_midframe();
        test_overrun(1'b1);
        test_random();
        n_checks++; if (both_cnt != 0 || long_cnt != 0) begin n_fail++; $display("FAIL pulse_shape: got both=%0d long=%0d want 0 0", both_cnt, long_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, clk cycles per serial bit; SHALL be an even integer >= 4.
REQ-002 Parameter FIFO_DEPTH, default 4, receive byte buffer entries; SHALL be a power of 2, >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rd_en  input  1  pop request for FIFO head.
REQ-007 dout  output  8  FIFO head byte, valid while empty=0.
REQ-008 empty  output  1  FIFO holds 0 bytes.
REQ-009 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: valid byte dropped, FIFO full.

Function
REQ-012 rxd SHALL pass a 2-flop synchronizer (flops reset to 1) before any use; "line" below means synchronizer output.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; a bit counter (0..CLKS_PER_BIT-1) and bit index (0..7).
REQ-014 IDLE: line=0 -> START, bit counter cleared to 0.
REQ-015 START: at bit counter = CLKS_PER_BIT/2-1 sample line; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, nothing written, no flags).
REQ-016 DATA: sample line each time counter reaches CLKS_PER_BIT-1 (bit centre), shift into bit index position (LSB first), counter wraps to 0; after index 7 sampled -> STOP.
REQ-017 STOP: sample at counter = CLKS_PER_BIT-1; line=1 -> byte is valid, go IDLE; line=0 -> frame_err pulse, byte discarded, go WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until line=1, then IDLE (no restart on held break).
REQ-019 Valid byte SHALL be written to FIFO in the cycle after the stop sample; empty SHALL deassert and dout show the byte one cycle after that write.
REQ-020 FIFO SHALL be first-word-fall-through; dout = oldest unread byte; pop on rising edge with rd_en=1 and empty=0.
REQ-021 rd_en while empty=1 SHALL be ignored (no pointer change, no error).
REQ-022 Write with full=1 and rd_en=1 in same cycle SHALL be accepted (pop and push both occur, count unchanged); write with full=1 and rd_en=0 SHALL be dropped and overrun pulse 1 cycle.
REQ-023 Simultaneous push/pop when not full/empty SHALL leave count unchanged.
REQ-024 Read/write pointers SHALL be log2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-025 frame_err and overrun SHALL never be asserted in the same cycle and never for more than 1 cycle per frame.

Reset
REQ-026 clr=1 SHALL immediately force: FSM IDLE, counters 0, shift register 0, synchronizer 1, FIFO pointers/count 0, empty=1, full=0, dout=0, frame_err=0, overrun=0.
REQ-027 clr asserted mid-frame SHALL discard the partial byte; receiver SHALL resume with the next falling edge after clr release.
REQ-028 FIFO storage contents need not be cleared; dout SHALL read 0 while empty=1.

Verification (CLKS_PER_BIT=8, clk 20 ns, bit 160 ns)
REQ-029 Send 0x55 with valid stop, rd_en=0 -> empty falls, dout=0x55, frame_err/overrun stay 0.
REQ-030 rxd low 60 ns then high -> no write, empty=1, FSM back to IDLE, no flags.
REQ-031 Send 0xA3 with stop bit low 320 ns -> exactly one frame_err pulse, empty=1; following 0x3C received correctly after line high.
REQ-032 Send 0x01..0x05, rd_en=0 -> full=1 after 4th, one overrun pulse on 5th; pops return 0x01..0x04, then empty=1.
REQ-033 Pulse clr during bit 4 of 0xFF, then send 0x81 -> only 0x81 in FIFO, count 1.
REQ-034 FIFO full, hold rd_en=1 during 5th byte write cycle -> no overrun, pops return 0x02..0x05.
